amm_byte_op: RTL and testbench
==============================

Name: amm_byte_op

Overview:
- Parametrised successor to the byte-increment engine.
- Reads a region of Avalon-MM memory, applies a selectable per-byte operation, and writes the result back to the same addresses.
- Reads are pipelined, with up to MAX_OUTSTANDING in flight, and buffered in an internal FIFO so the read and write masters overlap.
- Sits between a control/settings interface and two Avalon-MM masters: read and write.

Parameters:
- DATA_WIDTH, 64, Avalon data width in bits; multiple of 8.
- ADDR_WIDTH, 10, word address width.
- BYTE_CNT, DATA_WIDTH/8, bytes per word.
- MAX_OUTSTANDING, 4, maximum in-flight reads; also the FIFO depth; power of 2, at least 1.
- LEN_WIDTH, ADDR_WIDTH+$clog2(BYTE_CNT)+1, width of the byte-length field.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  asynchronous active-low reset.
- base_addr_i  in  ADDR_WIDTH  start word address.
- length_i  in  LEN_WIDTH  region length in bytes.
- op_i  in  2  operation: 00 INC (+1), 01 ADD operand, 10 XOR operand, 11 SUB operand.
- operand_i  in  8  byte operand for ADD/XOR/SUB.
- run_i  in  1  start request.
- waitrequest_o  out  1  high while busy; start requests are ignored while high.
- done_o  out  1  one-cycle pulse when the last write is accepted.
- amm_rd_address_o  out  ADDR_WIDTH  read address.
- amm_rd_read_o  out  1  read request.
- amm_rd_readdata_i  in  DATA_WIDTH  read data.
- amm_rd_readdatavalid_i  in  1  read data valid.
- amm_rd_waitrequest_i  in  1  read slave stall.
- amm_wr_address_o  out  ADDR_WIDTH  write address.
- amm_wr_write_o  out  1  write request.
- amm_wr_writedata_o  out  DATA_WIDTH  write data.
- amm_wr_byteenable_o  out  BYTE_CNT  write byte enables.
- amm_wr_waitrequest_i  in  1  write slave stall.

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - All outputs 0: waitrequest_o=0, done_o=0, read/write=0, address/data/byteenable=0.
  - FIFO emptied, counters cleared, FSM to IDLE.
  - Reset mid-operation aborts immediately. No further bus activity after release; outstanding readdatavalid returning after reset is ignored.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - run_i=1 with length_i>0: latch base_addr_i, length_i, op_i, operand_i; waitrequest_o=1 from the next cycle; go to RUN.
  - run_i=1 with length_i=0: no-op; stays IDLE, no done_o.
- Word count: WORDS = ceil(length/BYTE_CNT).
- Read side (RUN):
  - amm_rd_read_o is asserted while words_requested<WORDS and credits>0.
  - credits = MAX_OUTSTANDING − (in-flight + FIFO occupancy).
  - A read is accepted on a cycle with read=1 and rd_waitrequest=0; the address then increments.
  - Address and read stay stable while rd_waitrequest=1.
  - Addresses wrap modulo 2^ADDR_WIDTH.
  - When words_requested reaches WORDS, go to DRAIN.
- Data capture: every readdatavalid pushes readdata into the FIFO. The credit scheme guarantees no overflow.
- Write side, in both RUN and DRAIN:
  - When the FIFO is non-empty, present write=1 with the transformed word.
  - Address = latched base + write index.
  - Stay stable while wr_waitrequest=1; pop on acceptance.
- Per-byte operation, mod 256 (wrap):
  - INC: b+1.
  - ADD: b+operand.
  - XOR: b^operand.
  - SUB: b−operand.
- Byteenable:
  - All ones except on the last word.
  - Last word: low (length mod BYTE_CNT) bits set, or all ones if the remainder is 0.
  - Disabled bytes pass through unmodified in writedata.
- Latency:
  - Earliest write is 1 cycle after the corresponding readdatavalid (registered transform).
  - With no stalls the throughput is 1 word/cycle.
- Completion: when words_written reaches WORDS:
  - done_o pulses for 1 cycle.
  - waitrequest_o=0 in the same cycle.
  - FSM to IDLE.
  - A new run_i is accepted on the next cycle.
- Simultaneous push and pop on the FIFO in one cycle: occupancy is unchanged; this is legal at full and at empty+push.
- Config inputs are sampled only at start; changes during a run have no effect.

Optional Feature:
- Macro AMM_BYTE_OP_SAT_EN.
- Defined: ADD, INC and SUB saturate (INC/ADD clamp to 0xFF, SUB clamps to 0x00). XOR is unchanged.
- Undefined: all arithmetic wraps mod 256. No extra logic is generated.

Test Plan:
- base=0x010, length=16, op=INC, memory bytes 0x00..0x0F, no stalls -> 2 reads and 2 writes at 0x010/0x011, bytes 0x01..0x10, byteenable 0xFF; done_o pulses once; waitrequest_o returns to 0.
- length=13, op=XOR, operand=0xA5 -> 2 writes; second word byteenable=0x1F; written bytes equal original^0xA5.
- base=0x3FF, length=24, random rd/wr waitrequest 50%, readdatavalid latency 3 -> addresses 0x3FF, 0x000, 0x001; never more than 4 reads outstanding; data correct; no writes dropped.
- op=ADD, operand=0x02, byte 0xFF -> 0x01 when AMM_BYTE_OP_SAT_EN is undefined, 0xFF when defined. SUB of 0x03 from 0x01 -> 0xFE / 0x00 respectively.
- run_i with length=0 -> no bus activity, waitrequest_o stays 0. run_i pulsed while busy -> ignored; run completes with the original parameters.
- rst_n_i asserted mid-run with 2 reads outstanding -> all outputs 0 asynchronously; late readdatavalid ignored; a fresh run afterwards completes correctly.

Source files
------------

// File: rtl/amm_byte_op.sv
`default_nettype none
// ============================================================================
// amm_byte_op : Avalon-MM read-modify-write engine applying INC/ADD/XOR/SUB
//               to every byte of a memory region. Define AMM_BYTE_OP_SAT_EN
//               for saturating INC/ADD/SUB. Revision: 1.0
// ============================================================================
module amm_byte_op #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 10,
  parameter int BYTE_CNT        = DATA_WIDTH/8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = ADDR_WIDTH+$clog2(BYTE_CNT)+1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic [1:0]            op_i,
  input  logic [7:0]            operand_i,
  input  logic                  run_i,
  output logic                  waitrequest_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] amm_rd_address_o,
  output logic                  amm_rd_read_o,
  input  logic [DATA_WIDTH-1:0] amm_rd_readdata_i,
  input  logic                  amm_rd_readdatavalid_i,
  input  logic                  amm_rd_waitrequest_i,
  output logic [ADDR_WIDTH-1:0] amm_wr_address_o,
  output logic                  amm_wr_write_o,
  output logic [DATA_WIDTH-1:0] amm_wr_writedata_o,
  output logic [BYTE_CNT-1:0]   amm_wr_byteenable_o,
  input  logic                  amm_wr_waitrequest_i
);

  localparam int CNT_W = LEN_WIDTH + 1;
  localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [1:0]            r_op;
  logic [7:0]            r_operand;
  logic [CNT_W-1:0]      r_words;
  logic [BYTE_CNT-1:0]   r_last_be;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [OCC_W-1:0]      r_inflight;
  logic [OCC_W-1:0]      r_occ;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_mem [MAX_OUTSTANDING];

  logic                  w_start;
  logic [CNT_W-1:0]      w_words_in;
  logic [LEN_WIDTH-1:0]  w_rem;
  logic [BYTE_CNT-1:0]   w_start_be;
  logic [OCC_W:0]        w_pending;
  logic                  w_rd;
  logic                  w_rd_acc;
  logic                  w_push;
  logic                  w_wr;
  logic                  w_pop;
  logic                  w_last_wr;
  logic                  w_wr_done;
  logic [BYTE_CNT-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [7:0] byte_op(input logic [1:0] op, input logic [7:0] b,
                                         input logic [7:0] k);
`ifdef AMM_BYTE_OP_SAT_EN
    logic [8:0] sum;
    logic [8:0] dif;
    logic [7:0] res;
    sum = {1'b0, b} + ((op == 2'b00) ? 9'd1 : {1'b0, k});
    dif = {1'b0, b} - {1'b0, k};
    case (op)
      2'b10:   res = b ^ k;
      2'b11:   res = dif[8] ? 8'h00 : dif[7:0];
      default: res = sum[8] ? 8'hFF : sum[7:0];
    endcase
    return res;
`else
    logic [7:0] res;
    case (op)
      2'b00:   res = b + 8'd1;
      2'b01:   res = b + k;
      2'b10:   res = b ^ k;
      default: res = b - k;
    endcase
    return res;
`endif
  endfunction

  assign w_start    = (r_state == S_IDLE) && run_i && (length_i != '0);
  assign w_words_in = (CNT_W'(length_i) + CNT_W'(BYTE_CNT - 1)) / CNT_W'(BYTE_CNT);
  assign w_rem      = length_i % LEN_WIDTH'(BYTE_CNT);

  always_comb begin
    w_start_be = '0;
    for (int b = 0; b < BYTE_CNT; b++) begin
      w_start_be[b] = (w_rem == '0) || (LEN_WIDTH'(b) < w_rem);
    end
  end

  // Credits: reads in flight plus buffered words never exceed the FIFO depth.
  assign w_pending = (OCC_W+1)'(r_inflight) + (OCC_W+1)'(r_occ);
  assign w_rd      = (r_state == S_RUN) && (r_rd_cnt < r_words) &&
                     (w_pending < (OCC_W+1)'(MAX_OUTSTANDING));
  assign w_rd_acc  = w_rd && !amm_rd_waitrequest_i;
  // Data with nothing in flight is a leftover from an aborted run.
  assign w_push    = amm_rd_readdatavalid_i && (r_inflight != '0);
  assign w_wr      = (r_state != S_IDLE) && (r_occ != '0);
  assign w_pop     = w_wr && !amm_wr_waitrequest_i;
  assign w_last_wr = (r_wr_cnt == r_words - CNT_W'(1));
  assign w_wr_done = w_pop && w_last_wr;
  assign w_be      = w_last_wr ? r_last_be : '1;

  always_comb begin
    w_wdata = r_mem[r_rd_ptr];
    for (int b = 0; b < BYTE_CNT; b++) begin
      if (w_be[b]) begin
        w_wdata[8*b +: 8] = byte_op(r_op, r_mem[r_rd_ptr][8*b +: 8], r_operand);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_wr_done) begin
          w_state_nxt = S_IDLE;
        end else if (w_rd_acc && (r_rd_cnt + CNT_W'(1) == r_words)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (w_wr_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_base     <= '0;
      r_rd_addr  <= '0;
      r_op       <= '0;
      r_operand  <= '0;
      r_words    <= '0;
      r_last_be  <= '0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_inflight <= '0;
      r_occ      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_wr_done;
      if (w_start) begin
        r_base    <= base_addr_i;
        r_rd_addr <= base_addr_i;
        r_op      <= op_i;
        r_operand <= operand_i;
        r_words   <= w_words_in;
        r_last_be <= w_start_be;
        r_rd_cnt  <= '0;
        r_wr_cnt  <= '0;
      end else begin
        if (w_rd_acc) begin
          r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
          r_rd_cnt  <= r_rd_cnt + CNT_W'(1);
        end
        if (w_pop) r_wr_cnt <= r_wr_cnt + CNT_W'(1);
      end
      r_inflight <= r_inflight + OCC_W'(w_rd_acc) - OCC_W'(w_push);
      r_occ      <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= amm_rd_readdata_i;
  end

  assign waitrequest_o       = (r_state != S_IDLE);
  assign done_o              = r_done;
  assign amm_rd_read_o       = w_rd;
  assign amm_rd_address_o    = w_rd ? r_rd_addr : '0;
  assign amm_wr_write_o      = w_wr;
  assign amm_wr_address_o    = w_wr ? (r_base + ADDR_WIDTH'(r_wr_cnt)) : '0;
  assign amm_wr_writedata_o  = w_wr ? w_wdata : '0;
  assign amm_wr_byteenable_o = w_wr ? w_be : '0;

endmodule
`default_nettype wire

// File: tb/tb_amm_byte_op.sv
`default_nettype none
// Bench for amm_byte_op: random Avalon-MM slaves and a byte-level reference model.
module tb_amm_byte_op;
  localparam int AW = 10;
  localparam int LW = 14;
  localparam int MEMW = 1024;
`ifdef AMM_BYTE_OP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
  logic [1:0]    op = '0;
  logic [7:0]    operand = '0;
  logic          run = 1'b0;
  logic          waitreq, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_read, wr_write;
  logic [63:0]   rdata = '0;
  logic          rdv = 1'b0, rd_wait = 1'b0, wr_wait = 1'b0;
  logic [63:0]   wdata;
  logic [7:0]    be;

  always #5 clk = ~clk;

  amm_byte_op dut (
    .clk_i(clk), .rst_n_i(rst_n), .base_addr_i(base_addr), .length_i(length),
    .op_i(op), .operand_i(operand), .run_i(run), .waitrequest_o(waitreq), .done_o(done),
    .amm_rd_address_o(rd_addr), .amm_rd_read_o(rd_read), .amm_rd_readdata_i(rdata),
    .amm_rd_readdatavalid_i(rdv), .amm_rd_waitrequest_i(rd_wait),
    .amm_wr_address_o(wr_addr), .amm_wr_write_o(wr_write), .amm_wr_writedata_o(wdata),
    .amm_wr_byteenable_o(be), .amm_wr_waitrequest_i(wr_wait)
  );

  typedef struct { int addr; logic [63:0] data; logic [7:0] be; } wr_t;
  typedef struct { int addr; int due; } rd_t;

  logic [63:0] mem [MEMW];
  wr_t  exp_wr_q[$];
  int   exp_rd_q[$];
  rd_t  pend_q[$];
  int   rd_log[$];
  int   cyc = 0, errors = 0, checks = 0, done_cnt = 0, max_pend = 0;
  int   rd_wait_pct = 0, wr_wait_pct = 0, lat_min = 1, lat_max = 1;
  bit   busy = 0, done_exp = 0;
  bit   prev_rd_stall = 0, prev_wr_stall = 0;
  logic [AW-1:0] prev_rd_addr, prev_wr_addr;
  logic [63:0]   prev_wdata;
  logic [7:0]    prev_be, last_be = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Byte rule from the operation table, in plain integer arithmetic.
  function automatic logic [7:0] ref_op(input int o, input int b, input int k);
    int r;
    case (o)
      0: r = b + 1;
      1: r = b + k;
      2: r = b ^ k;
      default: r = b - k;
    endcase
    if (SAT && o != 2) begin
      if (r > 255) r = 255;
      if (r < 0) r = 0;
    end
    return 8'(r & 255);
  endfunction

  task automatic model_start(input int b, input int len, input int o, input int k);
    int words;
    wr_t w;
    words = (len + 7) / 8;
    for (int i = 0; i < words; i++) begin
      w.addr = (b + i) % MEMW;
      w.data = mem[w.addr];
      w.be = '0;
      for (int j = 0; j < 8; j++) begin
        if (i*8 + j < len) begin
          w.be[j] = 1'b1;
          w.data[8*j +: 8] = ref_op(o, int'(mem[w.addr][8*j +: 8]), k);
        end
      end
      exp_rd_q.push_back(w.addr);
      exp_wr_q.push_back(w);
    end
  endtask

  // Bus slaves plus compare process: observe at negedge, drive just after posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs", {waitreq, done, rd_read, wr_write, |rd_addr, |wr_addr, |wdata, |be}, 0);
        exp_wr_q.delete(); exp_rd_q.delete();
        busy = 0; done_exp = 0; prev_rd_stall = 0; prev_wr_stall = 0;
      end else begin
        bit busy_cur, done_nxt;
        busy_cur = busy;
        done_nxt = 0;
        chk("waitrequest", waitreq, busy_cur);
        chk("done", done, done_exp);
        if (done) done_cnt++;
        if (prev_rd_stall) begin
          chk("rd_hold_read", rd_read, 1);
          chk("rd_hold_addr", rd_addr, prev_rd_addr);
        end
        if (prev_wr_stall) begin
          chk("wr_hold_write", wr_write, 1);
          chk("wr_hold_addr", wr_addr, prev_wr_addr);
          chk("wr_hold_data", wdata, prev_wdata);
          chk("wr_hold_be", be, prev_be);
        end
        if (rd_read && !rd_wait) begin
          rd_t p;
          if (exp_rd_q.size() == 0) chk("unexpected_read", 1, 0);
          else chk("rd_addr", rd_addr, exp_rd_q.pop_front());
          p.addr = int'(rd_addr);
          p.due = cyc + $urandom_range(lat_max, lat_min);
          pend_q.push_back(p);
          rd_log.push_back(int'(rd_addr));
          if (pend_q.size() > max_pend) max_pend = pend_q.size();
          chk("outstanding_le_4", pend_q.size() <= 4, 1);
        end
        if (wr_write && !wr_wait) begin
          if (exp_wr_q.size() == 0) chk("unexpected_write", 1, 0);
          else begin
            wr_t e;
            e = exp_wr_q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wdata, e.data);
            chk("wr_be", be, e.be);
            for (int j = 0; j < 8; j++) if (be[j]) mem[wr_addr][8*j +: 8] = wdata[8*j +: 8];
            last_be = be;
            if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0) begin
              done_nxt = 1; busy = 0;
            end
          end
        end
        if (!busy_cur && run && length != 0) begin
          model_start(int'(base_addr), int'(length), int'(op), int'(operand));
          busy = 1;
        end
        done_exp = done_nxt;
        prev_rd_stall = rd_read && rd_wait; prev_rd_addr = rd_addr;
        prev_wr_stall = wr_write && wr_wait; prev_wr_addr = wr_addr;
        prev_wdata = wdata; prev_be = be;
      end
      @(posedge clk);
      cyc++;
      #1;
      rd_wait = ($urandom_range(99) < rd_wait_pct);
      wr_wait = ($urandom_range(99) < wr_wait_pct);
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        rdv = 1'b1;
        rdata = mem[pend_q[0].addr];
        void'(pend_q.pop_front());
      end else begin
        rdv = 1'b0;
        rdata = {$urandom, $urandom};
      end
    end
  end

  task automatic do_run(input int b, input int len, input int o, input int k, input bit poke);
    bit fin;
    @(posedge clk); #1;
    base_addr = AW'(b); length = LW'(len); op = 2'(o); operand = 8'(k); run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    base_addr = AW'($urandom); length = LW'($urandom); op = 2'($urandom); operand = 8'($urandom);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      base_addr = AW'(12'h200); length = LW'(8); op = 2'd2; operand = 8'h5A; run = 1'b1;
      @(posedge clk); #1;
      run = 1'b0;
    end
    fin = 0;
    for (int n = 0; n < 3000 && !fin; n++) begin
      @(negedge clk); #1;
      if (!busy && exp_wr_q.size() == 0) fin = 1;
    end
    if (!fin) chk("run_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] o0, o1, w;
    int dc;
    for (int i = 0; i < MEMW; i++) mem[i] = {$urandom, $urandom};
    chk("model_inc_ff", ref_op(0, 8'hFF, 0), SAT ? 8'hFF : 8'h00);
    chk("model_add_sat", ref_op(1, 8'hFF, 8'h02), SAT ? 8'hFF : 8'h01);
    chk("model_sub_sat", ref_op(3, 8'h01, 8'h03), SAT ? 8'h00 : 8'hFE);
    chk("model_xor", ref_op(2, 8'h3C, 8'hA5), 8'h99);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_waitreq", waitreq, 0);
    chk("reset_done", done, 0);
    rst_n = 1'b1;

    // INC over 16 ascending bytes, no stalls
    mem[16] = 64'h0706050403020100;
    mem[17] = 64'h0F0E0D0C0B0A0908;
    dc = done_cnt;
    do_run(16, 16, 0, 0, 0);
    chk("inc_word0", mem[16], 64'h0807060504030201);
    chk("inc_word1", mem[17], 64'h100F0E0D0C0B0A09);
    chk("inc_done_once", done_cnt - dc, 1);
    chk("inc_idle_after", waitreq, 0);

    // XOR, partial last word
    o0 = mem[32]; o1 = mem[33];
    do_run(32, 13, 2, 8'hA5, 0);
    chk("xor_word0", mem[32], o0 ^ 64'hA5A5A5A5A5A5A5A5);
    chk("xor_word1", mem[33], o1 ^ 64'h000000A5A5A5A5A5);
    chk("xor_last_be", last_be, 8'h1F);

    // Address wrap with heavy stalls and read latency 3
    rd_wait_pct = 50; wr_wait_pct = 50; lat_min = 3; lat_max = 3;
    rd_log.delete(); max_pend = 0;
    do_run(10'h3FF, 24, 1, 8'h37, 0);
    chk("wrap_nreads", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      chk("wrap_addr0", rd_log[0], 10'h3FF);
      chk("wrap_addr1", rd_log[1], 10'h000);
      chk("wrap_addr2", rd_log[2], 10'h001);
    end
    chk("wrap_max_outstanding", max_pend <= 4, 1);

    // Wrap vs saturate on ADD and SUB
    rd_wait_pct = 0; wr_wait_pct = 0; lat_min = 1; lat_max = 2;
    mem[10'h100] = 64'h00000000000000FF;
    do_run(10'h100, 1, 1, 8'h02, 0);
    w = mem[10'h100];
    chk("add_ff_plus_2", w[7:0], SAT ? 8'hFF : 8'h01);
    chk("add_masked_byte", w[15:8], 8'h00);
    mem[10'h101] = 64'h0000000000000001;
    do_run(10'h101, 1, 3, 8'h03, 0);
    w = mem[10'h101];
    chk("sub_1_minus_3", w[7:0], SAT ? 8'h00 : 8'hFE);

    // Zero length is a no-op
    rd_log.delete(); dc = done_cnt;
    do_run(10'h050, 0, 0, 0, 0);
    repeat (4) @(negedge clk);
    chk("len0_no_reads", rd_log.size(), 0);
    chk("len0_no_done", done_cnt - dc, 0);

    // Start request while busy is ignored
    rd_wait_pct = 30; wr_wait_pct = 30;
    o0 = mem[10'h200];
    do_run(10'h060, 40, 0, 0, 1);
    chk("busy_poke_ignored", mem[10'h200], o0);

    // Asynchronous reset with two reads outstanding
    rd_wait_pct = 0; wr_wait_pct = 0; lat_min = 6; lat_max = 6;
    @(posedge clk); #1;
    base_addr = AW'(10'h080); length = LW'(64); op = 2'd0; run = 1'b1;
    @(posedge clk); #1;
    run = 1'b0;
    dc = 0;
    for (int n = 0; n < 20 && dc == 0; n++) begin
      @(negedge clk); #1;
      if (pend_q.size() == 2) dc = 1;
    end
    chk("reset_two_outstanding", dc, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {waitreq, done, rd_read, wr_write, |rd_addr, |wr_addr, |wdata, |be}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 0; n < 20 && pend_q.size() > 0; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("late_data_drained", pend_q.size(), 0);
    lat_min = 1; lat_max = 4;
    do_run(10'h080, 20, 3, 8'h11, 0);

    // Random runs
    for (int t = 0; t < 12; t++) begin
      rd_wait_pct = $urandom_range(60); wr_wait_pct = $urandom_range(60);
      lat_min = 1; lat_max = $urandom_range(5, 1);
      do_run($urandom_range(MEMW-1), $urandom_range(200, 1), $urandom_range(3), $urandom_range(255), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
